// File: rtl/nmi_event_source_pkg.sv
// rtl/nmi_event_source_pkg.sv - shared constants and state encodings for the NMI hot-key event source
package nmi_event_source_pkg;

   localparam logic [7:0] NMIMASK_DEFAULT = 8'h0A;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_CTRL  = 8'h14;
   localparam logic [7:0] SC_ALT   = 8'h11;
   localparam logic [7:0] SC_F1    = 8'h05;
   localparam logic [7:0] SC_F2    = 8'h06;
   localparam logic [7:0] SC_F3    = 8'h04;
   localparam logic [7:0] SC_F4    = 8'h0C;
   localparam logic [7:0] SC_F5    = 8'h03;

   typedef enum logic [1:0] {
      P_IDLE = 2'd0,
      P_E0   = 2'd1,
      P_F0   = 2'd2,
      P_E0F0 = 2'd3
   } prefix_state_t;

   typedef enum logic [1:0] {
      D_ARMED    = 2'd0,
      D_WAIT_ACK = 2'd1,
      D_IN_NMI   = 2'd2,
      D_HOLDOFF  = 2'd3
   } deliver_state_t;

   function automatic logic [4:0] fkey_bit(input logic [7:0] code);
      logic [4:0] bits;
      bits = 5'b00000;
      case (code)
         SC_F1:   bits = 5'b00001;
         SC_F2:   bits = 5'b00010;
         SC_F3:   bits = 5'b00100;
         SC_F4:   bits = 5'b01000;
         SC_F5:   bits = 5'b10000;
         default: bits = 5'b00000;
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/nmi_event_source_decoder.sv
// rtl/nmi_event_source_decoder.sv - PS/2 prefix/modifier decoder producing ctrl+alt+F1..F5 hits
module ps2_hotkey_decoder
   import nmi_event_source_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] scancode,
   input  logic       scancode_valid,
   output logic [4:0] hit,
   output logic       strobe
);

   prefix_state_t state;
   prefix_state_t state_next;
   logic          consume;
   logic          is_break;
   logic          is_ext;
   logic          lctrl;
   logic          lalt;
   logic          rctrl;
   logic          ralt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= P_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      consume    = 1'b0;
      is_break   = 1'b0;
      is_ext     = 1'b0;
      if (scancode_valid) begin
         case (state)
            P_IDLE: begin
               if (scancode == SC_EXT) begin
                  state_next = P_E0;
               end else if (scancode == SC_BREAK) begin
                  state_next = P_F0;
               end else begin
                  consume = 1'b1;
               end
            end
            P_E0: begin
               if (scancode == SC_BREAK) begin
                  state_next = P_E0F0;
               end else begin
                  consume    = 1'b1;
                  is_ext     = 1'b1;
                  state_next = P_IDLE;
               end
            end
            P_F0: begin
               consume    = 1'b1;
               is_break   = 1'b1;
               state_next = P_IDLE;
            end
            P_E0F0: begin
               consume    = 1'b1;
               is_break   = 1'b1;
               is_ext     = 1'b1;
               state_next = P_IDLE;
            end
            default: state_next = P_IDLE;
         endcase
      end
   end

   // Modifier flags follow make/break; left and right keys differ only by the E0 prefix.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lctrl <= 1'b0;
         lalt  <= 1'b0;
         rctrl <= 1'b0;
         ralt  <= 1'b0;
      end else if (consume) begin
         if (scancode == SC_CTRL) begin
            if (is_ext) rctrl <= ~is_break;
            else        lctrl <= ~is_break;
         end
         if (scancode == SC_ALT) begin
            if (is_ext) ralt <= ~is_break;
            else        lalt <= ~is_break;
         end
      end
   end

   assign strobe = consume;
   assign hit    = (consume && !is_break && !is_ext && (lctrl || rctrl) && (lalt || ralt))
                   ? fkey_bit(scancode) : 5'b00000;

endmodule

// File: rtl/nmi_event_source.sv
// rtl/nmi_event_source.sv - masked hot-key pending register and NMI delivery handshake
module nmi_event_source
   import nmi_event_source_pkg::*;
#(
   parameter logic [7:0] NMIMASK = NMIMASK_DEFAULT,
   parameter int         HOLDOFF = 16
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] scancode,
   input  logic       scancode_valid,
   input  logic [7:0] zxuno_addr,
   input  logic       zxuno_regwr,
   input  logic       zxuno_regrd,
   input  logic [7:0] din,
   input  logic       page_configrom_active,
   output logic [4:0] userevents,
   output logic [7:0] dout,
   output logic       oe_n
);

   localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   deliver_state_t dstate;
   deliver_state_t dstate_next;
   logic [4:0]     mask;
   logic [4:0]     pending;
   logic [4:0]     pending_next;
   logic [4:0]     clear_bits;
   logic [4:0]     hit;
   logic           strobe;
   logic [CW-1:0]  count;
   logic           count_load;
   logic           count_dec;
   logic           unused_din;

   ps2_hotkey_decoder u_decoder (
      .clk            (clk),
      .rst_n          (rst_n),
      .scancode       (scancode),
      .scancode_valid (scancode_valid),
      .hit            (hit),
      .strobe         (strobe)
   );

   always_comb begin
      dstate_next = dstate;
      clear_bits  = 5'b00000;
      count_load  = 1'b0;
      count_dec   = 1'b0;
      case (dstate)
         D_ARMED: begin
            if (page_configrom_active)  dstate_next = D_IN_NMI;
            else if (pending != 5'b0)   dstate_next = D_WAIT_ACK;
         end
         D_WAIT_ACK: begin
            if (page_configrom_active) begin
               clear_bits  = userevents;
               dstate_next = D_IN_NMI;
            end
         end
         D_IN_NMI: begin
            if (!page_configrom_active) begin
               count_load  = 1'b1;
               dstate_next = D_HOLDOFF;
            end
         end
         D_HOLDOFF: begin
            if (count == '0) dstate_next = D_ARMED;
            else             count_dec   = 1'b1;
         end
         default: dstate_next = D_ARMED;
      endcase
   end

   // Only the word the handler saw is retired; hits arriving in the acknowledge cycle survive.
   assign pending_next = (pending & ~clear_bits) | (strobe ? (hit & mask) : 5'b00000);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dstate     <= D_ARMED;
         pending    <= 5'b00000;
         mask       <= 5'b11111;
         userevents <= 5'b00000;
         count      <= '0;
      end else begin
         dstate     <= dstate_next;
         pending    <= pending_next;
         userevents <= (dstate_next == D_WAIT_ACK) ? pending_next : 5'b00000;
         if (zxuno_regwr && zxuno_addr == NMIMASK) mask <= din[4:0];
         if (count_load)     count <= CW'(HOLDOFF - 1);
         else if (count_dec) count <= count - CW'(1);
      end
   end

   assign dout       = {3'b000, mask};
   assign oe_n       = ~(zxuno_regrd && zxuno_addr == NMIMASK);
   assign unused_din = ^din[7:5];

endmodule

// File: tb/tb_nmi_event_source.sv
// tb/tb_nmi_event_source.sv - scoreboard bench for nmi_event_source with directed and random hot-key traffic
module tb_nmi_event_source;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] scancode;
   logic       scancode_valid;
   logic [7:0] zxuno_addr;
   logic       zxuno_regwr;
   logic       zxuno_regrd;
   logic [7:0] din;
   logic       page_configrom_active;
   logic [4:0] userevents;
   logic [7:0] dout;
   logic       oe_n;

   int         n_pass  = 0;
   int         n_total = 0;
   logic [4:0] exp_q[$];
   logic [4:0] prev_ue = 5'b0;
   logic [4:0] mon_exp;

   // reference model: held modifiers, current mask, accumulated expected word
   bit         m_lctrl, m_lalt, m_rctrl, m_ralt;
   logic [4:0] m_mask;
   logic [4:0] m_exp;

   always #5 clk = ~clk;

   nmi_event_source u_dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .scancode              (scancode),
      .scancode_valid        (scancode_valid),
      .zxuno_addr            (zxuno_addr),
      .zxuno_regwr           (zxuno_regwr),
      .zxuno_regrd           (zxuno_regrd),
      .din                   (din),
      .page_configrom_active (page_configrom_active),
      .userevents            (userevents),
      .dout                  (dout),
      .oe_n                  (oe_n)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && userevents != 5'b0 && prev_ue == 5'b0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_presentation", {27'b0, userevents}, 32'h0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("scoreboard_word", {27'b0, userevents}, {27'b0, mon_exp});
         end
      end
      prev_ue = userevents;
   end

   function automatic logic [4:0] fbit(input logic [7:0] code);
      case (code)
         8'h05:   return 5'b00001;
         8'h06:   return 5'b00010;
         8'h04:   return 5'b00100;
         8'h0C:   return 5'b01000;
         8'h03:   return 5'b10000;
         default: return 5'b00000;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      scancode       = b;
      scancode_valid = 1'b1;
      tick();
      scancode_valid = 1'b0;
   endtask

   task automatic key(input bit brk, input bit ext, input logic [7:0] code);
      if (ext) send_byte(8'hE0);
      if (brk) send_byte(8'hF0);
      send_byte(code);
      if (code == 8'h14) begin
         if (ext) m_rctrl = !brk; else m_lctrl = !brk;
      end else if (code == 8'h11) begin
         if (ext) m_ralt = !brk; else m_lalt = !brk;
      end else if (!brk && !ext && (m_lctrl || m_rctrl) && (m_lalt || m_ralt)) begin
         m_exp = m_exp | (fbit(code) & m_mask);
      end
   endtask

   task automatic write_mask(input logic [7:0] v);
      zxuno_addr  = 8'h0A;
      din         = v;
      zxuno_regwr = 1'b1;
      tick();
      zxuno_regwr = 1'b0;
      m_mask      = v[4:0];
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n   = 1'b1;
      m_lctrl = 0; m_lalt = 0; m_rctrl = 0; m_ralt = 0;
      m_mask  = 5'b11111;
      m_exp   = 5'b0;
   endtask

   task automatic wait_present(input int max_cycles, output bit ok);
      ok = 0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (userevents != 5'b0) begin
            ok = 1;
            break;
         end
      end
      tick();
   endtask

   task automatic ack();
      page_configrom_active = 1'b1;
      repeat (3) tick();
      page_configrom_active = 1'b0;
      repeat (20) tick();
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      bit quiet;
      quiet = 1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (userevents != 5'b0) quiet = 0;
      end
      check(name, {31'b0, quiet}, 32'h1);
      tick();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ok;
      logic [7:0] codes[10];
      logic [7:0] code;
      bit         brk;
      int         nkeys;

      codes = '{8'h14, 8'h11, 8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h14, 8'h11, 8'h1C};
      scancode = 8'h00; scancode_valid = 1'b0;
      zxuno_addr = 8'h00; zxuno_regwr = 1'b0; zxuno_regrd = 1'b0; din = 8'h00;
      page_configrom_active = 1'b0;
      rst_n = 1'b0;
      tick();

      // reset values
      zxuno_addr = 8'h0A; zxuno_regrd = 1'b1;
      @(negedge clk);
      check("reset_userevents", {27'b0, userevents}, 32'h0);
      check("reset_pending", {27'b0, u_dut.pending}, 32'h0);
      check("reset_dout", {24'b0, dout}, 32'h1F);
      check("reset_oe_n_read", {31'b0, oe_n}, 32'h0);
      zxuno_regrd = 1'b0;
      #1;
      check("oe_n_no_read", {31'b0, oe_n}, 32'h1);
      zxuno_regrd = 1'b1; zxuno_addr = 8'h0B;
      #1;
      check("oe_n_other_addr", {31'b0, oe_n}, 32'h1);
      zxuno_regrd = 1'b0;
      tick();
      do_reset();

      // ctrl+alt+F2: pending at N+1, presented at N+2, cleared by acknowledge
      exp_q.push_back(5'b00010);
      key(0, 0, 8'h14);
      key(0, 0, 8'h11);
      key(0, 0, 8'h06);
      @(negedge clk);
      check("f2_pending_n1", {27'b0, u_dut.pending}, 32'h02);
      check("f2_userevents_n1", {27'b0, userevents}, 32'h0);
      @(negedge clk);
      check("f2_userevents_n2", {27'b0, userevents}, 32'h02);
      tick();
      page_configrom_active = 1'b1;
      tick();
      @(negedge clk);
      check("f2_ack_clears", {27'b0, userevents}, 32'h0);
      check("f2_pending_cleared", {27'b0, u_dut.pending}, 32'h0);
      tick();
      page_configrom_active = 1'b0;
      repeat (20) tick();

      // F1 and F4 before acknowledge are presented as one word
      page_configrom_active = 1'b1;
      repeat (2) tick();
      exp_q.push_back(5'b01001);
      key(0, 0, 8'h05);
      key(0, 0, 8'h0C);
      page_configrom_active = 1'b0;
      wait_present(30, ok);
      check("f1f4_presented", {31'b0, ok}, 32'h1);
      check("f1f4_word", {27'b0, userevents}, 32'h09);
      ack();

      // F3 during the handler waits out the hold-off window
      page_configrom_active = 1'b1;
      repeat (2) tick();
      exp_q.push_back(5'b00100);
      key(0, 0, 8'h04);
      repeat (3) tick();
      page_configrom_active = 1'b0;
      expect_quiet("f3_holdoff_quiet", 17);
      wait_present(6, ok);
      check("f3_presented", {31'b0, ok}, 32'h1);
      check("f3_word", {27'b0, userevents}, 32'h04);
      ack();
      key(1, 0, 8'h14);
      key(1, 0, 8'h11);
      key(0, 0, 8'h05);
      expect_quiet("no_mods_no_hit", 25);

      // right ctrl + left alt + F5, then right ctrl released
      exp_q.push_back(5'b10000);
      key(0, 1, 8'h14);
      key(0, 0, 8'h11);
      key(0, 0, 8'h03);
      wait_present(10, ok);
      check("f5_presented", {31'b0, ok}, 32'h1);
      check("f5_word", {27'b0, userevents}, 32'h10);
      ack();
      key(1, 1, 8'h14);
      key(0, 0, 8'h03);
      expect_quiet("rctrl_released_no_hit", 30);
      key(1, 0, 8'h11);

      // masked F2 never presents; mask reads back
      write_mask(8'h01);
      key(0, 0, 8'h14);
      key(0, 0, 8'h11);
      key(0, 0, 8'h06);
      expect_quiet("masked_f2_quiet", 25);
      zxuno_addr = 8'h0A; zxuno_regrd = 1'b1;
      @(negedge clk);
      check("mask_dout", {24'b0, dout}, 32'h01);
      check("mask_oe_n", {31'b0, oe_n}, 32'h0);
      tick();
      zxuno_regrd = 1'b0;
      write_mask(8'h1F);

      // reset during WAIT_ACK discards the event
      exp_q.push_back(5'b00001);
      key(0, 0, 8'h05);
      wait_present(10, ok);
      check("f1_presented", {31'b0, ok}, 32'h1);
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      check("rst_wait_ack_userevents", {27'b0, userevents}, 32'h0);
      check("rst_wait_ack_pending", {27'b0, u_dut.pending}, 32'h0);
      tick();
      do_reset();
      zxuno_addr = 8'h0A; zxuno_regrd = 1'b1;
      @(negedge clk);
      check("rst_mask_dout", {24'b0, dout}, 32'h1F);
      tick();
      zxuno_regrd = 1'b0;
      expect_quiet("no_represent_after_reset", 40);

      // random rounds: keys typed inside the handler, delivered as one word afterwards
      do_reset();
      for (int r = 0; r < 40; r++) begin
         page_configrom_active = 1'b1;
         repeat (2) tick();
         if ($urandom_range(0, 3) == 0) write_mask(8'($urandom_range(0, 31)));
         m_exp = 5'b0;
         nkeys = $urandom_range(1, 6);
         for (int k = 0; k < nkeys; k++) begin
            code = codes[$urandom_range(0, 9)];
            brk  = (code == 8'h14 || code == 8'h11) ? ($urandom_range(0, 2) == 0) : 1'b0;
            key(brk, $urandom_range(0, 3) == 0, code);
            repeat ($urandom_range(0, 2)) tick();
         end
         page_configrom_active = 1'b0;
         if (m_exp != 5'b0) begin
            exp_q.push_back(m_exp);
            wait_present(40, ok);
            check("rnd_presented", {31'b0, ok}, 32'h1);
            ack();
         end else begin
            repeat (25) tick();
         end
      end

      repeat (5) tick();
      check("queue_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
